// File: rtl/da_spi_cfg_seq_if.sv
// Bundle between the SPI config sequencer, its external synchronous table and the DAC pins.
// The sequencer uses the master modport; the table/pin side uses the slave modport.
interface da_spi_cfg_seq_if #(
    parameter int unsigned N_ENTRIES = 14,
    parameter int unsigned MAX_BYTES = 4
);
    localparam int unsigned AW    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned DW    = 8 * MAX_BYTES;

    logic             start;
    logic [AW-1:0]    tbl_addr;
    logic [7:0]       tbl_instr;
    logic [LEN_W-1:0] tbl_len;
    logic [DW-1:0]    tbl_data;
    logic             DA_CS;
    logic             DA_SCLK;
    logic             DA_SPI_OUT;
    logic             busy;
    logic             DA_READY;

    modport master (
        input  start, tbl_instr, tbl_len, tbl_data,
        output tbl_addr, DA_CS, DA_SCLK, DA_SPI_OUT, busy, DA_READY
    );

    modport slave (
        output start, tbl_instr, tbl_len, tbl_data,
        input  tbl_addr, DA_CS, DA_SCLK, DA_SPI_OUT, busy, DA_READY
    );
endinterface

// File: rtl/da_spi_cfg_seq.sv
// Walks a configuration table and sends each entry as one SPI frame
// (instruction byte plus up to MAX_BYTES data bytes, MSB first, CPOL=0).
module da_spi_cfg_seq #(
    parameter int unsigned N_ENTRIES = 14,
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned CS_GAP    = 4
) (
    input logic              GCLK,
    input logic              reset,
    da_spi_cfg_seq_if.master bus
);
    localparam int unsigned AW      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int unsigned LEN_W   = $clog2(MAX_BYTES + 1);
    localparam int unsigned DW      = 8 * MAX_BYTES;
    localparam int unsigned SRW     = 7 + DW;
    localparam int unsigned BIT_W   = LEN_W + 3;
    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, HOLD, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic [SRW-1:0]   sr_q, sr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [LEN_W-1:0] eff_len_c;
    logic [DW-1:0]    data_al_c;

    // Clamp the length and left-align the live data bytes so the shifter sends byte L-1 first.
    always_comb begin
        eff_len_c = (bus.tbl_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : bus.tbl_len;
        data_al_c = bus.tbl_data << (32'(8) * (32'(MAX_BYTES) - 32'(eff_len_c)));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        sr_d    = sr_q;
        len_d   = len_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                len_d   = eff_len_c;
                sr_d    = {bus.tbl_instr[6:0], data_al_c};
                sdo_d   = bus.tbl_instr[7];
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                bit_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // Last bit index of the frame is 8*L+7.
                        if (bit_q == {len_q, 3'b111}) begin
                            state_d = HOLD;
                        end else begin
                            sdo_d = sr_q[SRW-1];
                            sr_d  = sr_q << 1;
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    sdo_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_d = '0;
                    if (addr_q < AW'(N_ENTRIES - 1)) begin
                        addr_d  = addr_q + AW'(1);
                        state_d = FETCH;
                    end else begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts any frame in flight: CS rises and SCLK parks low on the same edge.
    always_ff @(posedge GCLK) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            sr_q    <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.tbl_addr   = addr_q;
    assign bus.busy       = busy_q;
    assign bus.DA_READY   = ready_q;
    assign bus.DA_CS      = cs_q;
    assign bus.DA_SCLK    = sclk_q;
    assign bus.DA_SPI_OUT = sdo_q;
endmodule

// File: tb/tb_da_spi_cfg_seq.sv
// Randomized self-checking bench: a frame-level monitor compares the captured SPI traffic
// against frames computed directly from the table contents.
module tb_da_spi_cfg_seq;
    localparam int unsigned NE = 14;
    localparam int unsigned MB = 4;
    localparam int unsigned CD = 2;
    localparam int unsigned CG = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    da_spi_cfg_seq_if #(.N_ENTRIES(NE), .MAX_BYTES(MB)) bus0 ();
    da_spi_cfg_seq_if #(.N_ENTRIES(1),  .MAX_BYTES(MB)) bus1 ();

    da_spi_cfg_seq #(.N_ENTRIES(NE), .MAX_BYTES(MB), .CLK_DIV(CD), .CS_GAP(CG)) dut0 (
        .GCLK(clk), .reset(reset), .bus(bus0.master));
    da_spi_cfg_seq #(.N_ENTRIES(1), .MAX_BYTES(MB), .CLK_DIV(1), .CS_GAP(CG)) dut1 (
        .GCLK(clk), .reset(reset), .bus(bus1.master));

    logic [7:0]  m_instr [16];
    logic [2:0]  m_len   [16];
    logic [31:0] m_data  [16];

    // Synchronous table with one cycle of read latency.
    always @(posedge clk) begin
        bus0.tbl_instr <= m_instr[bus0.tbl_addr];
        bus0.tbl_len   <= m_len[bus0.tbl_addr];
        bus0.tbl_data  <= m_data[bus0.tbl_addr];
        bus1.tbl_instr <= 8'h03;
        bus1.tbl_len   <= 3'd1;
        bus1.tbl_data  <= 32'h0000_0080;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned eff_len(input int unsigned e);
        return (int'(m_len[e]) > int'(MB)) ? MB : int'(m_len[e]);
    endfunction

    // Byte j of entry e's frame: instruction first, then data bytes L-1 down to 0.
    function automatic logic [7:0] exp_byte(input int unsigned e, input int unsigned j);
        logic [31:0] w;
        int unsigned l;
        l = eff_len(e);
        if (j == 0) return m_instr[e];
        w = m_data[e] >> (8 * (l - j));
        return w[7:0];
    endfunction

    task automatic fill_table(input bit forced);
        for (int e = 0; e < 16; e++) begin
            m_instr[e] = {4'(e), 4'($urandom)};
            m_len[e]   = 3'($urandom_range(0, 7));
            m_data[e]  = $urandom;
        end
        if (forced) begin
            m_instr[0] = 8'h0A; m_len[0] = 3'd4; m_data[0] = 32'h80C3_C901;
            m_len[1] = 3'd0;
            m_len[2] = 3'd7;
        end
    endtask

    // Frame monitor for dut0.
    logic        mon_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned frames_seen = 0;
    int unsigned cs_len = 0;
    int unsigned rise_cyc = 0;
    int unsigned sclk_idle_bad = 0;
    int unsigned l_m;
    logic [7:0]  byte_got;
    logic        bits[$];
    logic        hi_val = 1'b0;
    logic        stable_ok = 1'b1;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0, prev_ready = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus0.busy && !prev_busy) begin
                frames_seen = 0;
                sclk_idle_bad = 0;
                bits.delete();
            end
            if (prev_cs && !bus0.DA_CS) begin
                if (frames_seen > 0) check("cs_gap", cyc - rise_cyc, CG + 2);
                check("addr_at_cs_fall", bus0.tbl_addr, frames_seen);
                bits.delete();
                cs_len = 0;
                stable_ok = 1'b1;
            end
            if (!bus0.DA_CS) begin
                cs_len++;
                if (bus0.DA_SCLK && !prev_sclk) begin
                    bits.push_back(bus0.DA_SPI_OUT);
                    hi_val = bus0.DA_SPI_OUT;
                end else if (bus0.DA_SCLK && bus0.DA_SPI_OUT !== hi_val) begin
                    stable_ok = 1'b0;
                end
            end else if (bus0.DA_SCLK) begin
                sclk_idle_bad++;
            end
            if (!prev_cs && bus0.DA_CS) begin
                if (frames_seen < NE) begin
                    l_m = eff_len(frames_seen);
                end else begin
                    l_m = 0;
                    check("extra_frame", frames_seen, NE - 1);
                end
                check("nbits", bits.size(), 8 * (1 + l_m));
                for (int j = 0; j <= int'(l_m); j++) begin
                    if (bits.size() >= 8 * (j + 1) && frames_seen < NE) begin
                        byte_got = '0;
                        for (int k = 0; k < 8; k++) byte_got = {byte_got[6:0], bits[8*j+k]};
                        check($sformatf("e%0d_byte%0d", frames_seen, j), byte_got,
                              exp_byte(frames_seen, j));
                    end
                end
                check("cs_low_len", cs_len, 16 * (1 + l_m) * CD + CD);
                check("sdo_stable", stable_ok, 1);
                check("addr_at_cs_rise", bus0.tbl_addr, frames_seen);
                rise_cyc = cyc;
                frames_seen++;
            end
            if (bus0.DA_READY && !prev_ready) begin
                check("busy_at_ready", bus0.busy, 0);
                check("ready_delay", cyc - rise_cyc, CG);
                check("frames_at_ready", frames_seen, NE);
                check("sclk_idle", sclk_idle_bad, 0);
            end
        end
        prev_cs    = bus0.DA_CS;
        prev_sclk  = bus0.DA_SCLK;
        prev_busy  = bus0.busy;
        prev_ready = bus0.DA_READY;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start0(input bit expect_accept);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        if (expect_accept) begin
            check("busy_after_start", bus0.busy, 1);
            check("ready_after_start", bus0.DA_READY, 0);
        end
    endtask

    task automatic wait_ready0(input int unsigned budget);
        bit got;
        got = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            tick();
            if (bus0.DA_READY) begin
                got = 1'b1;
                break;
            end
        end
        check("ready_timeout", got, 1);
    endtask

    task automatic wait_frames0(input int unsigned n, input int unsigned budget);
        bit got;
        got = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            tick();
            if (frames_seen >= n) begin
                got = 1'b1;
                break;
            end
        end
        check("frames_timeout", got, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"},    bus0.DA_CS, 1);
        check({tag, "_sclk"},  bus0.DA_SCLK, 0);
        check({tag, "_sdo"},   bus0.DA_SPI_OUT, 0);
        check({tag, "_busy"},  bus0.busy, 0);
        check({tag, "_ready"}, bus0.DA_READY, 0);
        check({tag, "_addr"},  bus0.tbl_addr, 0);
    endtask

    // Single-entry, CLK_DIV=1 instance: 0x03 then 0x80, CS low 33 cycles.
    task automatic run_small();
        int unsigned rises, low_len, cs_rise_at, ready_at;
        logic [15:0] word;
        logic p_cs, p_sclk;
        bit got;
        rises = 0; low_len = 0; cs_rise_at = 0; ready_at = 0; word = '0; got = 1'b0;
        p_cs = bus1.DA_CS; p_sclk = bus1.DA_SCLK;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int unsigned i = 0; i < 400; i++) begin
            tick();
            if (!bus1.DA_CS) begin
                low_len++;
                if (bus1.DA_SCLK && !p_sclk) begin
                    rises++;
                    word = {word[14:0], bus1.DA_SPI_OUT};
                end
            end
            if (!p_cs && bus1.DA_CS) cs_rise_at = i;
            if (bus1.DA_READY) begin
                ready_at = i;
                got = 1'b1;
                check("small_busy_at_ready", bus1.busy, 0);
                break;
            end
            p_cs = bus1.DA_CS;
            p_sclk = bus1.DA_SCLK;
        end
        check("small_ready_timeout", got, 1);
        check("small_sclk_rises", rises, 16);
        check("small_bits", word, 16'h0380);
        check("small_cs_low", low_len, 33);
        check("small_ready_delay", ready_at - cs_rise_at, CG);
        check("small_addr", bus1.tbl_addr, 0);
    endtask

    initial begin
        int unsigned quiet_bad;
        bit hit;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        fill_table(1'b1);
        repeat (3) tick();
        check_reset_vals("rst");
        check("rst_small_cs", bus1.DA_CS, 1);
        reset = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        mon_en = 1'b1;

        // Run 1, with a start pulse during the run that must be ignored.
        pulse_start0(1'b1);
        wait_frames0(3, 3000);
        repeat ($urandom_range(0, 20)) tick();
        pulse_start0(1'b0);
        wait_ready0(6000);

        // DONE holds its outputs; a start there replays from entry 0.
        fill_table(1'b0);
        repeat ($urandom_range(3, 10)) tick();
        check("done_ready", bus0.DA_READY, 1);
        check("done_cs", bus0.DA_CS, 1);
        check("done_sclk", bus0.DA_SCLK, 0);
        pulse_start0(1'b1);
        wait_ready0(6000);

        // Reset during the third bit of entry 2, with a simultaneous start.
        fill_table(1'b1);
        pulse_start0(1'b1);
        hit = 1'b0;
        for (int unsigned i = 0; i < 3000; i++) begin
            tick();
            if (frames_seen == 2 && !bus0.DA_CS && bus0.DA_SCLK && bits.size() == 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_point_timeout", hit, 1);
        mon_en = 1'b0;
        reset = 1'b1;
        bus0.start = 1'b1;
        tick();
        check_reset_vals("abort");
        reset = 1'b0;
        bus0.start = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!bus0.DA_CS || bus0.DA_SCLK || bus0.busy || bus0.DA_READY) quiet_bad++;
        end
        check("post_reset_quiet", quiet_bad, 0);
        mon_en = 1'b1;
        pulse_start0(1'b1);
        wait_ready0(6000);

        run_small();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/da_spi_cfg_seq.md
DA_SPI_CFG_SEQ -- requirements
Module: da_spi_cfg_seq

Interface
REQ-001 Parameter N_ENTRIES, default 14, number of table entries sent per start; legal range 1..256.
REQ-002 Parameter MAX_BYTES, default 4, maximum data bytes per transaction after the instruction byte; legal range 1..4.
REQ-003 Parameter CLK_DIV, default 2, number of GCLK cycles per DA_SCLK half-period; minimum 1.
REQ-004 Parameter CS_GAP, default 4, number of GCLK cycles DA_CS stays high between transactions; minimum 1.
REQ-005 GCLK  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to run the whole table from entry 0.
REQ-008 tbl_addr  out  clog2(N_ENTRIES) (minimum 1)  entry index presented to the external synchronous table.
REQ-009 tbl_instr  in  8  instruction/address byte; valid one cycle after tbl_addr changes.
REQ-010 tbl_len  in  clog2(MAX_BYTES+1)  number of data bytes for this entry; valid with tbl_instr.
REQ-011 tbl_data  in  8*MAX_BYTES  data bytes; byte k is tbl_data[8k+7:8k].
REQ-012 DA_CS  out  1  active-low chip select.
REQ-013 DA_SCLK  out  1  SPI clock; idles low (CPOL=0).
REQ-014 DA_SPI_OUT  out  1  serial data, MSB first; the slave samples it on the DA_SCLK rising edge.
REQ-015 busy  out  1  high from start acceptance until DA_READY rises.
REQ-016 DA_READY  out  1  sticky completion flag for the whole table.

Function
REQ-017 FSM states: IDLE, FETCH, LOAD, SHIFT, HOLD, GAP, DONE.
REQ-018 start is accepted in IDLE or DONE on the edge where it is sampled high: tbl_addr<=0, busy<=1, DA_READY<=0, next state FETCH; start in any other state is ignored.
REQ-019 FETCH lasts 1 cycle (table latency).
REQ-020 LOAD lasts 1 cycle, on the edge that ends it:
- tbl_instr and tbl_data are captured.
- Effective length L is set to min(tbl_len, MAX_BYTES).
- DA_CS<=0 and DA_SPI_OUT<=tbl_instr[7].
- Next state SHIFT.
REQ-021 Frame content: 8*(1+L) bits in order instr[7:0], then data byte L-1 down to byte 0, each byte MSB first; L=0 sends the instruction byte only.
REQ-022 Bit cell in SHIFT is 2*CLK_DIV cycles: DA_SCLK low for the first CLK_DIV cycles, high for the next CLK_DIV cycles.
REQ-023 DA_SPI_OUT changes only on the edge where DA_SCLK goes high-to-low, or in LOAD; it is constant while DA_SCLK is high.
REQ-024 After the high phase of the last bit: DA_SCLK<=0, state HOLD for CLK_DIV cycles with DA_CS low; then DA_CS<=1, DA_SPI_OUT<=0, state GAP.
REQ-025 GAP lasts CS_GAP cycles with DA_CS high and DA_SCLK low.
REQ-026 At the end of GAP:
- If tbl_addr < N_ENTRIES-1: tbl_addr increments and the next state is FETCH.
- Otherwise: the next state is DONE, DA_READY<=1 and busy<=0.
REQ-027 DONE holds DA_READY=1, DA_CS=1 and DA_SCLK=0 until reset or an accepted start.
REQ-028 Transaction length in GCLK cycles, from DA_CS falling to DA_CS rising, is 16*(1+L)*CLK_DIV + CLK_DIV.
REQ-029 Bit and byte counters wrap only at frame end; tbl_addr never exceeds N_ENTRIES-1.
REQ-030 If start and reset are high in the same cycle, reset wins.
REQ-031 Entry 0 of the table has no special meaning beyond being the first entry sent.

Reset
REQ-032 On reset the outputs take these values on the next edge:
- DA_CS=1, DA_SCLK=0, DA_SPI_OUT=0.
- busy=0, DA_READY=0, tbl_addr=0.
- State IDLE.
REQ-033 Reset asserted mid-frame aborts the frame on that edge: DA_CS rises with no further DA_SCLK edges, and no partial resume occurs after reset.

Verification
REQ-034 N_ENTRIES=1, CLK_DIV=1, entry {instr=0x03, len=1, data=0x80} -> 16 DA_SCLK rising edges, captured bits 0x03 then 0x80, DA_CS low for 33 cycles, DA_READY rises CS_GAP cycles after DA_CS rises.
REQ-035 MAX_BYTES=4, entry {instr=0x0A, len=4, data=0x80C3C901} -> bytes sent 0x0A,0x80,0xC3,0xC9,0x01; entry with len=0 -> only the instruction byte is sent.
REQ-036 Entry with tbl_len=7 and MAX_BYTES=4 -> exactly 40 bits are sent (clamped to 4 data bytes).
REQ-037 Default parameters, 14 distinct entries -> 14 DA_CS low pulses, each separated by at least 4 high cycles, tbl_addr sequence 0..13, busy deasserts in the same cycle DA_READY rises.
REQ-038 start pulsed again while busy -> ignored and the sequence is unchanged; start in DONE -> DA_READY clears and the table replays from entry 0.
REQ-039 reset asserted in the middle of the third bit of entry 2 -> DA_CS=1, DA_SCLK=0, DA_SPI_OUT=0 next cycle; a subsequent start begins at entry 0.
